// File: rtl/des_cmd_sequencer_if.sv
// Bus bundle between the sweep sequencer, its requester, the DES wrapper and the result sink.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface des_cmd_sequencer_if #(
  parameter int unsigned REGION_W = 16,
  parameter int unsigned COUNT_W  = 64
);
  logic                req_valid;
  logic                req_ready;
  logic [REGION_W-1:0] region_first;
  logic [REGION_W-1:0] region_last;
  logic [1:0]          cmd;
  logic                cmd_valid;
  logic                cmd_read;
  logic [REGION_W-1:0] region_out;
  logic                done;
  logic [COUNT_W-1:0]  counter_in;
  logic                res_valid;
  logic                res_ready;
  logic [REGION_W-1:0] res_region;
  logic [COUNT_W-1:0]  res_counter;
  logic                busy;
  logic                sweep_done;
  logic                err;

  modport master (
    input  req_valid, region_first, region_last, cmd_read, done, counter_in, res_ready,
    output req_ready, cmd, cmd_valid, region_out, res_valid, res_region, res_counter,
           busy, sweep_done, err
  );

  modport slave (
    output req_valid, region_first, region_last, cmd_read, done, counter_in, res_ready,
    input  req_ready, cmd, cmd_valid, region_out, res_valid, res_region, res_counter,
           busy, sweep_done, err
  );
endinterface

// File: rtl/des_cmd_sequencer.sv
// Walks an inclusive range of regions through the DES wrapper (read region, start,
// wait for done, capture counter, stream result, output read) one region at a time.
module des_cmd_sequencer #(
  parameter int unsigned REGION_W = 16,
  parameter int unsigned COUNT_W  = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  des_cmd_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SET_REGION, START, WAIT_DONE, CAPTURE, PUSH, ACK, NEXT
  } state_t;

  localparam logic [1:0] CMD_READ_REGION = 2'd0;
  localparam logic [1:0] CMD_START       = 2'd1;
  localparam logic [1:0] CMD_OUT_READ    = 2'd2;

  state_t              state_q;
  logic [REGION_W-1:0] cur_q;
  logic [REGION_W-1:0] last_q;
  logic [REGION_W-1:0] region_out_q;
  logic [REGION_W-1:0] res_region_q;
  logic [COUNT_W-1:0]  res_counter_q;
  logic [1:0]          cmd_q;
  logic                cmd_valid_q;
  logic                res_valid_q;
  logic                busy_q;
  logic                sweep_done_q;
  logic                err_q;
  logic                req_ready_q;

  logic cmd_hs_c;
  logic res_hs_c;

  assign cmd_hs_c = cmd_valid_q && bus.cmd_read;
  assign res_hs_c = res_valid_q && bus.res_ready;

  // Sweep FSM; every output is a register updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      last_q        <= '0;
      region_out_q  <= '0;
      res_region_q  <= '0;
      res_counter_q <= '0;
      cmd_q         <= CMD_READ_REGION;
      cmd_valid_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      err_q         <= 1'b0;
      req_ready_q   <= 1'b1;
    end else begin
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            cur_q  <= bus.region_first;
            last_q <= bus.region_last;
            if (bus.region_last < bus.region_first) begin
              err_q <= 1'b1;
            end else begin
              err_q        <= 1'b0;
              region_out_q <= bus.region_first;
              cmd_q        <= CMD_READ_REGION;
              cmd_valid_q  <= 1'b1;
              busy_q       <= 1'b1;
              req_ready_q  <= 1'b0;
              state_q      <= SET_REGION;
            end
          end
        end

        SET_REGION: begin
          if (cmd_hs_c) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_READ_REGION;
            state_q     <= START;
          end
        end

        // One idle cycle separates consecutive commands so a consumed command never lingers.
        START: begin
          if (!cmd_valid_q) begin
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_START;
          end else if (bus.cmd_read) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_READ_REGION;
            state_q     <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (bus.done) begin
            state_q <= CAPTURE;
          end
        end

        // The wrapper's counter settles one cycle after done, so sample on the way out.
        CAPTURE: begin
          res_counter_q <= bus.counter_in;
          res_region_q  <= cur_q;
          res_valid_q   <= 1'b1;
          state_q       <= PUSH;
        end

        PUSH: begin
          if (res_hs_c) begin
            res_valid_q <= 1'b0;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_OUT_READ;
            state_q     <= ACK;
          end
        end

        ACK: begin
          if (cmd_hs_c) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_READ_REGION;
            state_q     <= NEXT;
          end
        end

        // Compare before incrementing so a sweep ending at the all-ones region never wraps.
        NEXT: begin
          if (cur_q == last_q) begin
            sweep_done_q <= 1'b1;
            busy_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end else begin
            cur_q        <= cur_q + REGION_W'(1);
            region_out_q <= cur_q + REGION_W'(1);
            cmd_q        <= CMD_READ_REGION;
            cmd_valid_q  <= 1'b1;
            state_q      <= SET_REGION;
          end
        end

        default: begin
          cmd_valid_q <= 1'b0;
          cmd_q       <= CMD_READ_REGION;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.region_out  = region_out_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_region  = res_region_q;
  assign bus.res_counter = res_counter_q;
  assign bus.busy        = busy_q;
  assign bus.sweep_done  = sweep_done_q;
  assign bus.err         = err_q;

  a_cmd_zero_when_invalid: assert property (
    @(posedge clk) disable iff (!rst_n) !cmd_valid_q |-> (cmd_q == CMD_READ_REGION));

  a_cmd_valid_drops: assert property (
    @(posedge clk) disable iff (!rst_n) cmd_hs_c |=> !cmd_valid_q);

endmodule

// File: tb/tb_des_cmd_sequencer.sv
// Bench for des_cmd_sequencer: behavioural DES wrapper, result sink, directed sweep table
// and hand-written backpressure and mid-sweep reset sequences.
module tb_des_cmd_sequencer;

  localparam int unsigned REGION_W   = 16;
  localparam int unsigned COUNT_W    = 64;
  localparam logic [63:0] CNT_BASE   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CNT_JUNK   = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int          DONE_DELAY = 20;

  typedef struct {
    logic [15:0] first;
    logic [15:0] last;
    int          n_res;
    int          n_cmd;
    logic        exp_err;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_cmd_sequencer_if #(.REGION_W(REGION_W), .COUNT_W(COUNT_W)) bus ();

  des_cmd_sequencer #(.REGION_W(REGION_W), .COUNT_W(COUNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;

  logic [1:0]  cmd_log[$];
  logic [15:0] creg_log[$];
  logic [15:0] rreg_log[$];
  logic [63:0] rcnt_log[$];
  int          sweep_pulses     = 0;
  int          cmd_valid_cycles = 0;
  int          cmd_idle_bad     = 0;
  logic [15:0] model_region;

  // Counter value the wrapper model reports for a region; region 5 yields the base value.
  function automatic logic [63:0] exp_count(input logic [15:0] r);
    return CNT_BASE ^ {48'd0, r ^ 16'd5};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [15:0] f, input logic [15:0] l);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.region_first = f;
    bus.region_last  = l;
    @(negedge clk);
    bus.req_valid    = 1'b0;
  endtask

  task automatic wait_sweep(input string name, input int s0);
    int n;
    n = 0;
    while (sweep_pulses == s0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sweep_done_seen"}, 64'(sweep_pulses != s0), 64'd1);
  endtask

  // DES wrapper model: consumes every command, raises done after a start,
  // presents the counter only in the cycle after done.
  initial begin : wrapper_model
    int   cd;
    logic show;
    cd = 0;
    show = 1'b0;
    model_region = '0;
    bus.cmd_read   = 1'b0;
    bus.done       = 1'b0;
    bus.counter_in = CNT_JUNK;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.cmd_read   = 1'b0;
        bus.done       = 1'b0;
        bus.counter_in = CNT_JUNK;
        cd   = 0;
        show = 1'b0;
      end else begin
        bus.cmd_read = bus.cmd_valid;
        if (bus.cmd_valid && bus.cmd == 2'd0) model_region = bus.region_out;
        if (bus.cmd_valid && bus.cmd == 2'd1) cd = DONE_DELAY;
        if (show) begin
          bus.counter_in = CNT_JUNK;
          show = 1'b0;
        end
        if (bus.done) begin
          bus.done       = 1'b0;
          bus.counter_in = exp_count(model_region);
          show = 1'b1;
        end else if (cd > 0) begin
          cd--;
          if (cd == 0) bus.done = 1'b1;
        end
      end
    end
  end

  // Handshake recorder: values read at the clock edge are the ones the DUT acts on.
  initial begin : monitor
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (bus.cmd_valid && bus.cmd_read) begin
          cmd_log.push_back(bus.cmd);
          creg_log.push_back(bus.region_out);
        end
        if (bus.res_valid && bus.res_ready) begin
          rreg_log.push_back(bus.res_region);
          rcnt_log.push_back(bus.res_counter);
        end
        if (bus.sweep_done) sweep_pulses++;
        if (bus.cmd_valid) cmd_valid_cycles++;
        if (!bus.cmd_valid && bus.cmd != 2'd0) cmd_idle_bad++;
      end
    end
  end

  initial begin : main
    vec_t        vecs[5];
    int          c0, r0, s0, cv0, rdy_drop, n;
    logic        stable;
    logic [15:0] held_region;
    logic [63:0] held_cnt;
    logic [15:0] exp_reg;

    vecs[0] = '{16'h0005, 16'h0005, 1, 3,  1'b0};
    vecs[1] = '{16'h0003, 16'h0006, 4, 12, 1'b0};
    vecs[2] = '{16'h0009, 16'h0002, 0, 0,  1'b1};
    vecs[3] = '{16'hFFFE, 16'hFFFF, 2, 6,  1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1, 3,  1'b0};

    bus.req_valid    = 1'b0;
    bus.region_first = '0;
    bus.region_last  = '0;
    bus.res_ready    = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cmd_valid",   64'(bus.cmd_valid),   64'd0);
    check("rst_cmd",         64'(bus.cmd),         64'd0);
    check("rst_res_valid",   64'(bus.res_valid),   64'd0);
    check("rst_busy_flags",  64'({bus.busy, bus.sweep_done, bus.err}), 64'd0);
    check("rst_region_out",  64'(bus.region_out),  64'd0);
    check("rst_res_payload", 64'(bus.res_region) | bus.res_counter, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready",   64'(bus.req_ready),   64'd1);

    for (int v = 0; v < 5; v++) begin
      c0  = cmd_log.size();
      r0  = rreg_log.size();
      s0  = sweep_pulses;
      cv0 = cmd_valid_cycles;
      rdy_drop = 0;
      send_req(vecs[v].first, vecs[v].last);
      if (vecs[v].exp_err) begin
        repeat (30) begin
          @(negedge clk);
          if (bus.req_ready !== 1'b1) rdy_drop++;
        end
        check($sformatf("v%0d_cmd_valid_cycles", v), 64'(cmd_valid_cycles - cv0), 64'd0);
        check($sformatf("v%0d_ready_drops", v), 64'(rdy_drop), 64'd0);
      end else begin
        wait_sweep($sformatf("v%0d", v), s0);
      end
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_err", v),       64'(bus.err),                  64'(vecs[v].exp_err));
      check($sformatf("v%0d_n_cmd", v),     64'(cmd_log.size() - c0),      64'(vecs[v].n_cmd));
      check($sformatf("v%0d_n_res", v),     64'(rreg_log.size() - r0),     64'(vecs[v].n_res));
      check($sformatf("v%0d_sweep_pulses", v), 64'(sweep_pulses - s0),
            vecs[v].exp_err ? 64'd0 : 64'd1);
      check($sformatf("v%0d_idle", v),      64'({bus.busy, bus.req_ready}), 64'd1);
      for (int i = 0; i < vecs[v].n_res && r0 + i < rreg_log.size(); i++) begin
        exp_reg = 16'(vecs[v].first + 16'(i));
        check($sformatf("v%0d_res%0d_region", v, i),  64'(rreg_log[r0 + i]), 64'(exp_reg));
        check($sformatf("v%0d_res%0d_counter", v, i), rcnt_log[r0 + i],      exp_count(exp_reg));
      end
      for (int i = 0; i < vecs[v].n_cmd && c0 + i < cmd_log.size(); i++) begin
        check($sformatf("v%0d_cmd%0d_code", v, i),   64'(cmd_log[c0 + i]), 64'(i % 3));
        check($sformatf("v%0d_cmd%0d_region", v, i), 64'(creg_log[c0 + i]),
              64'(16'(vecs[v].first + 16'(i / 3))));
      end
    end

    // Backpressure: result held for ten cycles with no output-read command.
    bus.res_ready = 1'b0;
    c0 = cmd_log.size();
    r0 = rreg_log.size();
    s0 = sweep_pulses;
    send_req(16'h0004, 16'h0004);
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("bp_res_valid", 64'(bus.res_valid), 64'd1);
    held_region = bus.res_region;
    held_cnt    = bus.res_counter;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_region !== held_region || bus.res_counter !== held_cnt ||
          bus.res_valid !== 1'b1 || bus.cmd_valid !== 1'b0) stable = 1'b0;
    end
    check("bp_payload_stable", 64'(stable),               64'd1);
    check("bp_region",         64'(held_region),          64'h4);
    check("bp_counter",        held_cnt,                  exp_count(16'h0004));
    check("bp_no_ack_yet",     64'(cmd_log.size() - c0),  64'd2);
    bus.res_ready = 1'b1;
    wait_sweep("bp", s0);
    repeat (3) @(negedge clk);
    check("bp_n_cmd",          64'(cmd_log.size() - c0),  64'd3);
    check("bp_n_res",          64'(rreg_log.size() - r0), 64'd1);
    if (cmd_log.size() == c0 + 3) check("bp_last_cmd", 64'(cmd_log[c0 + 2]), 64'd2);

    // Reset while waiting for done, then a fresh single-region sweep.
    c0 = cmd_log.size();
    send_req(16'h0003, 16'h0006);
    n = 0;
    while (cmd_log.size() < c0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("rs_busy_before", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_ctrl_zero",    64'({bus.cmd_valid, bus.cmd, bus.res_valid, bus.busy,
                                  bus.sweep_done, bus.err}), 64'd0);
    check("rs_region_out",   64'(bus.region_out), 64'd0);
    check("rs_res_payload",  64'(bus.res_region) | bus.res_counter, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = cmd_log.size();
    repeat (40) @(negedge clk);
    check("rs_no_reissue",   64'(cmd_log.size() - c0), 64'd0);
    check("rs_idle",         64'({bus.busy, bus.req_ready}), 64'd1);
    r0 = rreg_log.size();
    s0 = sweep_pulses;
    send_req(16'h0007, 16'h0007);
    wait_sweep("rs", s0);
    repeat (3) @(negedge clk);
    check("rs_n_cmd", 64'(cmd_log.size() - c0),  64'd3);
    check("rs_n_res", 64'(rreg_log.size() - r0), 64'd1);
    if (rreg_log.size() == r0 + 1) begin
      check("rs_res_region",  64'(rreg_log[r0]), 64'h7);
      check("rs_res_counter", rcnt_log[r0],      exp_count(16'h0007));
    end

    check("cmd_zero_when_invalid", 64'(cmd_idle_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
